hex_tx_formatter: RTL and testbench

Converts a binary result word from the multiplier datapath into uppercase ASCII hexadecimal characters, optionally followed by CR LF. It feeds the bytes one at a time into the UART transmitter through that transmitter's `tx_start`/`tx_data`/`tx_busy` handshake. It sits directly upstream of the UART transmitter, and it is the only block that drives the transmitter's inputs.

---
 rtl/hex_tx_formatter.sv | 112 +++++++++++
 tb/tb_hex_tx_formatter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_tx_formatter.sv
// Prints a result word as uppercase ASCII hex (optionally followed by CR LF) into a UART transmitter, one byte at a time.
// The first tx_start comes two cycles after start is accepted; each character waits on tx_busy, so a stalled transmitter stalls the frame.
module hex_tx_formatter #(
   parameter int DATA_W  = 16,
   parameter int NEWLINE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              done,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy
);

   localparam int NDIG  = DATA_W / 4;
   localparam int TOTAL = NDIG + 2 * NEWLINE;
   localparam int IDX_W = $clog2(TOTAL + 1);

   localparam logic [IDX_W-1:0] NDIG_I = IDX_W'(NDIG);
   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_shl;
   logic [7:0]        tx_data_q;
   logic [7:0]        char_d;
   logic              tx_start_q;
   logic              done_q;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign idx_d    = idx_q + IDX_W'(1);
   // Shifting left keeps the wanted nibble at the top and avoids negative shift amounts.
   assign data_shl = data_q << {idx_d, 2'b00};

   always_comb begin
      char_d = 8'h0A;
      if (idx_d < NDIG_I) begin
         char_d = hex_char(data_shl[DATA_W-1 -: 4]);
      end else if (idx_d == NDIG_I) begin
         char_d = 8'h0D;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         data_q     <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  data_q    <= data;
                  idx_q     <= '0;
                  tx_data_q <= hex_char(data[DATA_W-1 -: 4]);
                  state_q   <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  state_q    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               tx_start_q <= 1'b0;
               if (tx_busy) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (idx_q == LAST_I) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     idx_q     <= idx_d;
                     tx_data_q <= char_d;
                     state_q   <= SEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready    = (state_q == IDLE);
   assign done     = done_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Two formatter instances (16-bit with CR LF, 8-bit bare) driving a behavioural UART model with random byte times.
module tb_hex_tx_formatter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [15:0] data0 = '0;
   logic [7:0]  data1 = '0;
   logic        ext_busy = 1'b0;

   logic [1:0]  ready_w, done_w, tx_start_w, tx_busy_w;
   logic [7:0]  tx_data_w [2];

   int          checks = 0;
   int          errors = 0;

   // Behavioural transmitter state, one slot per instance.
   int          cnt [2];
   logic [7:0]  cur [2];
   logic [1:0]  prev_ts, prev_done;
   int          n_strobes [2];
   int          n_done [2];
   int          viol [2];
   logic [7:0]  rx0 [$];
   logic [7:0]  rx1 [$];

   always #5 clk = ~clk;

   hex_tx_formatter #(.DATA_W(16), .NEWLINE(1)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .data(data0),
      .ready(ready_w[0]), .done(done_w[0]), .tx_start(tx_start_w[0]),
      .tx_data(tx_data_w[0]), .tx_busy(tx_busy_w[0])
   );

   hex_tx_formatter #(.DATA_W(8), .NEWLINE(0)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .data(data1),
      .ready(ready_w[1]), .done(done_w[1]), .tx_start(tx_start_w[1]),
      .tx_data(tx_data_w[1]), .tx_busy(tx_busy_w[1])
   );

   assign tx_busy_w[0] = (cnt[0] != 0) || ext_busy;
   assign tx_busy_w[1] = (cnt[1] != 0);

   initial begin
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; cur[i] = 8'h00; n_strobes[i] = 0; n_done[i] = 0; viol[i] = 0;
      end
      prev_ts = '0;
      prev_done = '0;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt[0] <= 0;
         cnt[1] <= 0;
         prev_ts <= '0;
         prev_done <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            int v;
            v = 0;
            prev_ts[i] <= tx_start_w[i];
            prev_done[i] <= done_w[i];
            if (tx_start_w[i]) begin
               n_strobes[i] <= n_strobes[i] + 1;
               if (prev_ts[i]) v++;
            end
            if (done_w[i]) begin
               n_done[i] <= n_done[i] + 1;
               if (prev_done[i] || cnt[i] != 0) v++;
            end
            if (cnt[i] == 0) begin
               if (tx_start_w[i]) begin
                  cnt[i] <= $urandom_range(10, 4);
                  cur[i] <= tx_data_w[i];
                  if (i == 0) rx0.push_back(tx_data_w[i]);
                  else        rx1.push_back(tx_data_w[i]);
               end
            end else begin
               cnt[i] <= cnt[i] - 1;
               if (tx_data_w[i] !== cur[i]) v++;
               if (tx_start_w[i]) v++;
            end
            viol[i] <= viol[i] + v;
         end
      end
   end

   // Expected frame built from the digit arithmetic: most significant digit first.
   function automatic logic [63:0] ref_frame(input int unsigned d, input int ndig, input int nl, output int n);
      logic [63:0] r;
      int          dig;
      r = '0;
      n = 0;
      for (int k = 0; k < ndig; k++) begin
         dig = int'((d / (32'd1 << (4 * (ndig - 1 - k)))) % 16);
         r = (r << 8) | 64'(dig < 10 ? 48 + dig : 65 + dig - 10);
         n++;
      end
      if (nl != 0) begin
         r = (r << 8) | 64'h0D;
         r = (r << 8) | 64'h0A;
         n += 2;
      end
      return r;
   endfunction

   function automatic logic [63:0] pack_rx(input logic [7:0] q [$], input int from, output int n);
      logic [63:0] r;
      r = '0;
      n = q.size() - from;
      for (int k = from; k < q.size(); k++) r = (r << 8) | 64'(q[k]);
      return r;
   endfunction

   task automatic issue(input int i, input logic [15:0] d);
      @(negedge clk);
      if (i == 0) begin start0 = 1'b1; data0 = d; end
      else begin start1 = 1'b1; data1 = d[7:0]; end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      data0 = $urandom;
      data1 = $urandom;
   endtask

   task automatic wait_done(input int i, output bit to);
      to = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (done_w[i]) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++; if (ready_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ready%0d got %b exp 1", i, ready_w[i]); end
         checks++; if (done_w[i] !== 1'b0) begin errors++; $display("FAIL reset_done%0d got %b exp 0", i, done_w[i]); end
         checks++; if (tx_start_w[i] !== 1'b0) begin errors++; $display("FAIL reset_txstart%0d got %b exp 0", i, tx_start_w[i]); end
         checks++; if (tx_data_w[i] !== 8'h00) begin errors++; $display("FAIL reset_txdata%0d got %h exp 00", i, tx_data_w[i]); end
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_frames();
      logic [15:0] words [$];
      logic [63:0] exp, got;
      int          ne, ng, base, s0, d0, v0;
      bit          to;
      words = '{16'h3A7F, 16'h0000, 16'hFFFF};
      for (int k = 0; k < 12; k++) words.push_back(16'($urandom));
      foreach (words[w]) begin
         base = rx0.size(); s0 = n_strobes[0]; d0 = n_done[0]; v0 = viol[0];
         issue(0, words[w]);
         wait_done(0, to);
         checks++; if (to) begin errors++; $display("FAIL frame_timeout data %h got no done exp done", words[w]); end
         repeat (2) @(negedge clk);
         exp = ref_frame(32'(words[w]), 4, 1, ne);
         got = pack_rx(rx0, base, ng);
         checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL frame_bytes data %h got %h (%0d) exp %h (%0d)", words[w], got, ng, exp, ne); end
         checks++; if (n_strobes[0] - s0 != 6) begin errors++; $display("FAIL frame_strobes data %h got %0d exp 6", words[w], n_strobes[0] - s0); end
         checks++; if (n_done[0] - d0 != 1) begin errors++; $display("FAIL frame_done data %h got %0d exp 1", words[w], n_done[0] - d0); end
         checks++; if (viol[0] != v0) begin errors++; $display("FAIL frame_protocol data %h got %0d violations exp 0", words[w], viol[0] - v0); end
      end
   endtask

   task automatic test_ignored_start();
      logic [63:0] exp, got;
      int          ne, ng, base;
      bit          to, rdy_seen;
      base = rx0.size();
      issue(0, 16'hBEEF);
      repeat (8) @(negedge clk);
      rdy_seen = 1'b0;
      start0 = 1'b1; data0 = 16'h1234;
      repeat (5) begin @(negedge clk); rdy_seen |= ready_w[0]; end
      start0 = 1'b0;
      checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL ignored_ready got %b exp 0", rdy_seen); end
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL ignored_timeout got no done exp done"); end
      exp = ref_frame(32'hBEEF, 4, 1, ne);
      got = pack_rx(rx0, base, ng);
      checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL ignored_bytes got %h (%0d) exp %h (%0d)", got, ng, exp, ne); end
      base = rx0.size();
      issue(0, 16'h1234);
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL ignored_next_timeout got no done exp done"); end
      exp = ref_frame(32'h1234, 4, 1, ne);
      got = pack_rx(rx0, base, ng);
      checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL ignored_next_bytes got %h (%0d) exp %h (%0d)", got, ng, exp, ne); end
   endtask

   task automatic test_reset_midframe();
      logic [63:0] exp, got;
      int          ne, ng, base, d0;
      bit          to;
      base = rx0.size();
      issue(0, 16'hC0DE);
      to = 1'b1;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (rx0.size() >= base + 3) begin to = 1'b0; break; end
      end
      checks++; if (to) begin errors++; $display("FAIL midreset_third_char got %0d chars exp 3", rx0.size() - base); end
      @(negedge clk);
      d0 = n_done[0];
      reset = 1'b1;
      #1;
      checks++; if (tx_start_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_txstart got %b exp 0", tx_start_w[0]); end
      checks++; if (tx_data_w[0] !== 8'h00) begin errors++; $display("FAIL midreset_txdata got %h exp 00", tx_data_w[0]); end
      checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", ready_w[0]); end
      checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", done_w[0]); end
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (n_done[0] != d0) begin errors++; $display("FAIL midreset_no_done got %0d pulses exp 0", n_done[0] - d0); end
      base = rx0.size();
      issue(0, 16'h0042);
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL midreset_next_timeout got no done exp done"); end
      exp = ref_frame(32'h0042, 4, 1, ne);
      got = pack_rx(rx0, base, ng);
      checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL midreset_next_bytes got %h (%0d) exp %h (%0d)", got, ng, exp, ne); end
   endtask

   task automatic test_config();
      logic [63:0] exp, got;
      logic [7:0]  d;
      int          ne, ng, base, s0, d0, v0;
      bit          to;
      for (int k = 0; k < 4; k++) begin
         d = (k == 0) ? 8'hB5 : 8'($urandom);
         base = rx1.size(); s0 = n_strobes[1]; d0 = n_done[1]; v0 = viol[1];
         issue(1, {8'h00, d});
         wait_done(1, to);
         checks++; if (to) begin errors++; $display("FAIL cfg_timeout data %h got no done exp done", d); end
         repeat (2) @(negedge clk);
         exp = ref_frame(32'(d), 2, 0, ne);
         got = pack_rx(rx1, base, ng);
         checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL cfg_bytes data %h got %h (%0d) exp %h (%0d)", d, got, ng, exp, ne); end
         checks++; if (n_strobes[1] - s0 != 2 || n_done[1] - d0 != 1 || viol[1] != v0) begin
            errors++; $display("FAIL cfg_protocol data %h got strobes %0d done %0d viol %0d exp 2 1 0", d, n_strobes[1] - s0, n_done[1] - d0, viol[1] - v0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp, got;
      logic [15:0] d;
      int          ne, ng, base;
      bit          to;
      d = 16'($urandom);
      issue(0, 16'h5A5A);
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_first_timeout got no done exp done"); end
      checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b exp 1", ready_w[0]); end
      base = rx0.size();
      start0 = 1'b1; data0 = d;
      @(negedge clk);
      start0 = 1'b0;
      checks++; if (tx_start_w[0] !== 1'b0 || ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_cycle1 got ts %b rdy %b exp 0 0", tx_start_w[0], ready_w[0]); end
      @(negedge clk);
      checks++; if (tx_start_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_cycle2_strobe got %b exp 1", tx_start_w[0]); end
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_second_timeout got no done exp done"); end
      exp = ref_frame(32'(d), 4, 1, ne);
      got = pack_rx(rx0, base, ng);
      checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL b2b_bytes got %h (%0d) exp %h (%0d)", got, ng, exp, ne); end
   endtask

   task automatic test_busy_stall();
      logic [63:0] exp, got;
      int          ne, ng, base, s0;
      bit          to, ts_seen;
      base = rx0.size(); s0 = n_strobes[0];
      @(negedge clk);
      ext_busy = 1'b1;
      issue(0, 16'h9D17);
      ts_seen = 1'b0;
      repeat (100) begin @(negedge clk); ts_seen |= tx_start_w[0]; end
      checks++; if (ts_seen !== 1'b0 || n_strobes[0] != s0) begin errors++; $display("FAIL stall_strobe got %b exp 0", ts_seen); end
      checks++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", ready_w[0]); end
      ext_busy = 1'b0;
      wait_done(0, to);
      checks++; if (to) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
      exp = ref_frame(32'h9D17, 4, 1, ne);
      got = pack_rx(rx0, base, ng);
      checks++; if (got !== exp || ng != ne) begin errors++; $display("FAIL stall_bytes got %h (%0d) exp %h (%0d)", got, ng, exp, ne); end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_ignored_start();
      test_reset_midframe();
      test_config();
      test_back_to_back();
      test_busy_stall();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no completion exp finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
